// File: rtl/perf_snapshot_pkg.sv
`default_nettype none
// ============================================================================
// Module      : perf_snapshot_pkg
// Description : Shared definitions for the performance-snapshot APB block:
//               register offsets, STATUS bit layout, APB FSM state type and
//               a helper that assembles the STATUS word.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package perf_snapshot_pkg;

    // Register offsets (paddr_i[5:0])
    localparam logic [5:0] OFF_RUNTIME_LO = 6'h00;
    localparam logic [5:0] OFF_RUNTIME_HI = 6'h04;
    localparam logic [5:0] OFF_DCACHE_LO  = 6'h08;
    localparam logic [5:0] OFF_DCACHE_HI  = 6'h0C;
    localparam logic [5:0] OFF_ICACHE_LO  = 6'h10;
    localparam logic [5:0] OFF_ICACHE_HI  = 6'h14;
    localparam logic [5:0] OFF_SBFULL_LO  = 6'h18;
    localparam logic [5:0] OFF_SBFULL_HI  = 6'h1C;
    localparam logic [5:0] OFF_STATUS     = 6'h20;
    localparam logic [5:0] OFF_CTRL       = 6'h24;

    // STATUS layout
    localparam int STATUS_VALID_BIT = 0;
    localparam int STATUS_OVR_BIT   = 1;
    localparam int STATUS_CNT_LSB   = 8;
    localparam int STATUS_CNT_W     = 8;

    // Bank order: runtime, dcache, icache, sbfull (matches addr[4:3])
    localparam int NUM_BANKS = 4;

    typedef enum logic [0:0] {
        APB_IDLE = 1'b0,
        APB_ACK  = 1'b1
    } apb_state_e;

    function automatic logic [31:0] status_word(
        input logic                    valid,
        input logic                    ovr,
        input logic [STATUS_CNT_W-1:0] cnt
    );
        logic [31:0] w;
        w                                   = '0;
        w[STATUS_VALID_BIT]                 = valid;
        w[STATUS_OVR_BIT]                   = ovr;
        w[STATUS_CNT_LSB +: STATUS_CNT_W]   = cnt;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/perf_snapshot_bank.sv
`default_nettype none
// ============================================================================
// Module      : perf_snapshot_bank
// Description : One capture register of the snapshot block. Loads data_i
//               when load_i is high; reset has priority so a load in a
//               reset cycle is ignored.
// Ports       : clk_i  - clock
//               rst_i  - synchronous active-high reset
//               load_i - capture strobe
//               data_i - value to capture
//               data_o - captured value
// Revision    : 1.0 - initial release
// ============================================================================
module perf_snapshot_bank #(
    parameter int Width = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [Width-1:0] data_i,
    output logic [Width-1:0] data_o
);

    logic [Width-1:0] data_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= data_i;
        end
    end

    assign data_o = data_q;

endmodule
`default_nettype wire

// File: rtl/perf_snapshot_apb.sv
`default_nettype none
// ============================================================================
// Module      : perf_snapshot_apb
// Description : Captures four 64-bit performance counters on snap_valid_i
//               and exposes them, plus STATUS/CTRL, over an APB slave with
//               one wait state. HI words are served from a shadow loaded by
//               the matching LO read, so a LO-then-HI pair is coherent even
//               if a new snapshot lands in between.
// Ports       : clk_i, rst_i            - clock, sync active-high reset
//               snap_valid_i            - capture pulse
//               snap_runtime_i/dcache_i/icache_i/sbfull_i - counter inputs
//               psel_i, penable_i, pwrite_i, paddr_i, pwdata_i - APB request
//               prdata_o, pready_o, pslverr_o                  - APB response
// Revision    : 1.0 - initial release
// ============================================================================
module perf_snapshot_apb
    import perf_snapshot_pkg::*;
#(
    parameter int AddrWidth = 32,
    parameter int CntWidth  = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 snap_valid_i,
    input  logic [CntWidth-1:0]  snap_runtime_i,
    input  logic [CntWidth-1:0]  snap_dcache_i,
    input  logic [CntWidth-1:0]  snap_icache_i,
    input  logic [CntWidth-1:0]  snap_sbfull_i,
    input  logic                 psel_i,
    input  logic                 penable_i,
    input  logic                 pwrite_i,
    input  logic [AddrWidth-1:0] paddr_i,
    input  logic [31:0]          pwdata_i,
    output logic [31:0]          prdata_o,
    output logic                 pready_o,
    output logic                 pslverr_o
);

    // ---------------------------------------------------------------- banks
    logic [CntWidth-1:0] w_snap [NUM_BANKS];
    logic [CntWidth-1:0] w_bank [NUM_BANKS];

    assign w_snap[0] = snap_runtime_i;
    assign w_snap[1] = snap_dcache_i;
    assign w_snap[2] = snap_icache_i;
    assign w_snap[3] = snap_sbfull_i;

    generate
        for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
            perf_snapshot_bank #(
                .Width (CntWidth)
            ) u_bank (
                .clk_i  (clk_i),
                .rst_i  (rst_i),
                .load_i (snap_valid_i),
                .data_i (w_snap[g]),
                .data_o (w_bank[g])
            );
        end
    endgenerate

    // ------------------------------------------------------------- APB FSM
    apb_state_e state_q, state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            APB_IDLE: if (psel_i && penable_i) state_d = APB_ACK;
            APB_ACK:  state_d = APB_IDLE;
            default:  state_d = APB_IDLE;
        endcase
    end

    // Request is captured on entry to ACK so the response depends only on
    // registered state during the ACK cycle.
    logic [5:0] addr_q;
    logic       write_q;
    logic       wbit0_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= APB_IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            wbit0_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == APB_IDLE && psel_i && penable_i) begin
                addr_q  <= paddr_i[5:0];
                write_q <= pwrite_i;
                wbit0_q <= pwdata_i[0];
            end
        end
    end

    // Only paddr_i[5:0] and pwdata_i[0] carry meaning.
    logic w_unused;
    assign w_unused = ^{paddr_i[AddrWidth-1:6], pwdata_i[31:1]};

    // -------------------------------------------------------------- decode
    logic        w_in_ack;
    logic        w_err;
    logic        w_ok;
    logic        w_bank_area;
    logic        w_lo_read;
    logic        w_clear;
    logic [31:0] w_rdata;

    logic [31:0] shadow_q, shadow_d;
    logic        valid_q, valid_d;
    logic        ovr_q, ovr_d;
    logic [STATUS_CNT_W-1:0] cnt_q, cnt_d;

    assign w_in_ack    = (state_q == APB_ACK);
    assign w_bank_area = (addr_q < OFF_STATUS);

    always_comb begin
        w_err = (addr_q[1:0] != 2'b00)
             || (addr_q > OFF_CTRL)
             || (write_q && (addr_q <= OFF_STATUS))
             || (!write_q && (addr_q == OFF_CTRL));
    end

    assign w_ok      = w_in_ack && !w_err;
    assign w_lo_read = w_ok && !write_q && w_bank_area && !addr_q[2];
    assign w_clear   = w_ok && write_q && (addr_q == OFF_CTRL) && wbit0_q;

    // addr[4:3] picks the bank, addr[2] picks LO (live) vs HI (shadow).
    always_comb begin
        w_rdata = '0;
        if (w_bank_area) begin
            w_rdata = addr_q[2] ? shadow_q : w_bank[addr_q[4:3]][31:0];
        end else if (addr_q == OFF_STATUS) begin
            w_rdata = status_word(valid_q, ovr_q, cnt_q);
        end
    end

    assign pready_o  = w_in_ack;
    assign pslverr_o = w_in_ack && w_err;
    assign prdata_o  = (w_ok && !write_q) ? w_rdata : 32'h0;

    // ------------------------------------------------------- status/shadow
    // Clear is applied before the snapshot so that a simultaneous clear and
    // capture leaves exactly one fresh, non-overrun snapshot.
    always_comb begin
        shadow_d = shadow_q;
        valid_d  = valid_q;
        ovr_d    = ovr_q;
        cnt_d    = cnt_q;
        if (w_lo_read) begin
            shadow_d = w_bank[addr_q[4:3]][CntWidth-1:32];
        end
        if (w_clear) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
            cnt_d   = '0;
        end
        if (snap_valid_i) begin
            ovr_d   = ovr_d | valid_d;
            valid_d = 1'b1;
            if (cnt_d != {STATUS_CNT_W{1'b1}}) begin
                cnt_d = cnt_d + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shadow_q <= '0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            shadow_q <= shadow_d;
            valid_q  <= valid_d;
            ovr_q    <= ovr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_perf_snapshot_apb.sv
`default_nettype none
// ============================================================================
// Module      : tb_perf_snapshot_apb
// Description : Self-checking bench for perf_snapshot_apb. Directed vectors
//               from a table, hand-written corner sequences, and random
//               APB/snapshot traffic checked against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_perf_snapshot_apb;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        snap_valid_i;
    logic [63:0] sdata [4];
    logic        psel_i, penable_i, pwrite_i;
    logic [31:0] paddr_i, pwdata_i;
    logic [31:0] prdata_o;
    logic        pready_o, pslverr_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    perf_snapshot_apb #(
        .AddrWidth (32),
        .CntWidth  (64)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .snap_valid_i   (snap_valid_i),
        .snap_runtime_i (sdata[0]),
        .snap_dcache_i  (sdata[1]),
        .snap_icache_i  (sdata[2]),
        .snap_sbfull_i  (sdata[3]),
        .psel_i         (psel_i),
        .penable_i      (penable_i),
        .pwrite_i       (pwrite_i),
        .paddr_i        (paddr_i),
        .pwdata_i       (pwdata_i),
        .prdata_o       (prdata_o),
        .pready_o       (pready_o),
        .pslverr_o      (pslverr_o)
    );

    // ------------------------------------------------- behavioural model
    logic [63:0] m_bank [4];
    logic [31:0] m_shadow;
    bit          m_valid, m_ovr;
    int          m_cnt;

    task automatic m_reset();
        for (int k = 0; k < 4; k++) m_bank[k] = '0;
        m_shadow = '0; m_valid = 0; m_ovr = 0; m_cnt = 0;
    endtask

    function automatic logic [31:0] m_status();
        return {16'h0, 8'(m_cnt), 6'h0, m_ovr, m_valid};
    endfunction

    task automatic m_snapshot();
        if (m_valid) m_ovr = 1;
        m_valid = 1;
        if (m_cnt < 255) m_cnt = m_cnt + 1;
        for (int k = 0; k < 4; k++) m_bank[k] = sdata[k];
    endtask

    task automatic m_apb(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                         input bit snap, output logic [31:0] erd, output bit eerr);
        int off;
        off  = int'(a[5:0]);
        eerr = (off % 4 != 0) || (off > 36) || (wr && off <= 32) || (!wr && off == 36);
        erd  = '0;
        if (!eerr && !wr) begin
            if (off < 32) begin
                if (off % 8 == 0) begin
                    erd      = m_bank[off / 8][31:0];
                    m_shadow = m_bank[off / 8][63:32];
                end else begin
                    erd = m_shadow;
                end
            end else begin
                erd = m_status();
            end
        end
        if (!eerr && wr && off == 36 && wd[0]) begin
            m_valid = 0; m_ovr = 0; m_cnt = 0;
        end
        if (snap) m_snapshot();
    endtask

    // ------------------------------------------------------------ helpers
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic rand_sdata();
        for (int k = 0; k < 4; k++) sdata[k] = {$urandom(), $urandom()};
    endtask

    task automatic pulse();
        snap_valid_i = 1'b1;
        @(posedge clk_i); #1;
        snap_valid_i = 1'b0;
        m_snapshot();
    endtask

    // One APB transfer; lat = cycles from penable to pready (-1 on timeout).
    task automatic apb(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                       input bit snap_ack, output logic [31:0] rd,
                       output logic err, output int lat);
        psel_i = 1'b1; penable_i = 1'b0; pwrite_i = wr; paddr_i = a; pwdata_i = wd;
        @(posedge clk_i); #1;
        penable_i = 1'b1;
        lat = -1; rd = '0; err = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk_i); #1;
            if (pready_o) begin
                lat = i;
                break;
            end
        end
        if (lat > 0) begin
            rd  = prdata_o;
            err = pslverr_o;
            if (snap_ack) snap_valid_i = 1'b1;
            @(posedge clk_i); #1;
        end
        psel_i = 1'b0; penable_i = 1'b0; snap_valid_i = 1'b0;
    endtask

    task automatic run_op(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                          input bit snap, input logic [31:0] exp_rd, input bit exp_err,
                          input string name);
        logic [31:0] rd;
        logic        err;
        int          lat;
        apb(wr, a, wd, snap, rd, err, lat);
        check({name, "_rdata"}, rd, exp_rd);
        check({name, "_slverr"}, 32'(err), 32'(exp_err));
        check({name, "_latency"}, 32'(lat), 32'd1);
        check({name, "_idle"}, prdata_o | {30'h0, pready_o, pslverr_o}, 32'h0);
    endtask

    // Directed op: expectation supplied by caller, model kept in step.
    task automatic op_const(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                            input bit snap, input logic [31:0] exp_rd, input bit exp_err,
                            input string name);
        logic [31:0] mrd;
        bit          merr;
        m_apb(wr, a, wd, snap, mrd, merr);
        run_op(wr, a, wd, snap, exp_rd, exp_err, name);
    endtask

    // Random op: expectation from the model.
    task automatic op_model(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                            input bit snap, input string name);
        logic [31:0] mrd;
        bit          merr;
        m_apb(wr, a, wd, snap, mrd, merr);
        run_op(wr, a, wd, snap, mrd, merr, name);
    endtask

    // ------------------------------------------------------------ vectors
    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        bit          exp_err;
    } vec_t;

    vec_t vecs [18];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          off;
        bit          wr, snap;
        logic [31:0] a;

        // After the first snapshot below: runtime, dcache, icache, sbfull.
        vecs[0]  = '{1'b0, 32'h0000_0000, 32'h0, 32'h0000_00FF, 1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0004, 32'h0, 32'h0000_0001, 1'b0};
        vecs[2]  = '{1'b0, 32'h0000_0020, 32'h0, 32'h0000_0101, 1'b0};
        vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0, 32'h9ABC_DEF0, 1'b0};
        vecs[4]  = '{1'b0, 32'h0000_0014, 32'h0, 32'h1234_5678, 1'b0};
        vecs[5]  = '{1'b0, 32'h0000_001C, 32'h0, 32'h1234_5678, 1'b0};
        vecs[6]  = '{1'b0, 32'h0000_0018, 32'h0, 32'h0000_0042, 1'b0};
        vecs[7]  = '{1'b0, 32'h0000_001C, 32'h0, 32'hCAFE_F00D, 1'b0};
        vecs[8]  = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0, 1'b1};
        vecs[9]  = '{1'b0, 32'h0000_0024, 32'h0, 32'h0, 1'b1};
        vecs[10] = '{1'b0, 32'h0000_0002, 32'h0, 32'h0, 1'b1};
        vecs[11] = '{1'b0, 32'h0000_0028, 32'h0, 32'h0, 1'b1};
        vecs[12] = '{1'b1, 32'h0000_0028, 32'h1, 32'h0, 1'b1};
        vecs[13] = '{1'b1, 32'h0000_0020, 32'h1, 32'h0, 1'b1};
        vecs[14] = '{1'b0, 32'h0000_0004, 32'h0, 32'hCAFE_F00D, 1'b0};
        vecs[15] = '{1'b1, 32'h0000_0024, 32'h0, 32'h0, 1'b0};
        vecs[16] = '{1'b0, 32'h0000_0020, 32'h0, 32'h0000_0101, 1'b0};
        vecs[17] = '{1'b0, 32'hFFFF_FF00, 32'h0, 32'h0000_00FF, 1'b0};

        rst_i = 1'b1; snap_valid_i = 1'b0;
        psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
        paddr_i = '0; pwdata_i = '0;
        for (int k = 0; k < 4; k++) sdata[k] = '0;
        m_reset();

        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        check("reset_pready", 32'(pready_o), 32'h0);
        check("reset_pslverr", 32'(pslverr_o), 32'h0);
        check("reset_prdata", prdata_o, 32'h0);
        rst_i = 1'b0;
        op_const(0, 32'h20, 32'h0, 0, 32'h0, 0, "reset_status");
        op_const(0, 32'h00, 32'h0, 0, 32'h0, 0, "reset_runtime_lo");

        // Basic capture, then directed table
        sdata[0] = 64'h0000_0001_0000_00FF;
        sdata[1] = 64'hAAAA_0000_0000_0005;
        sdata[2] = 64'h1234_5678_9ABC_DEF0;
        sdata[3] = 64'hCAFE_F00D_0000_0042;
        pulse();
        for (int i = 0; i < 18; i++) begin
            op_const(vecs[i].wr, vecs[i].addr, vecs[i].wdata, 0,
                     vecs[i].exp_rd, vecs[i].exp_err, $sformatf("vec%0d", i));
        end

        // Shadow coherence across a new snapshot, and overrun
        op_const(0, 32'h08, 32'h0, 0, 32'h0000_0005, 0, "dc_lo_first");
        sdata[1] = 64'hBBBB_0000_0000_0006;
        pulse();
        op_const(0, 32'h0C, 32'h0, 0, 32'hAAAA_0000, 0, "dc_hi_shadow");
        op_const(0, 32'h20, 32'h0, 0, 32'h0000_0203, 0, "status_overrun");
        op_const(0, 32'h08, 32'h0, 0, 32'h0000_0006, 0, "dc_lo_second");
        op_const(0, 32'h0C, 32'h0, 0, 32'hBBBB_0000, 0, "dc_hi_second");

        // Clear coinciding with a capture
        op_const(1, 32'h24, 32'h1, 1, 32'h0, 0, "clr_with_snap");
        op_const(0, 32'h20, 32'h0, 0, 32'h0000_0101, 0, "status_clr_snap");

        // Plain clear leaves the banks intact
        op_const(1, 32'h24, 32'h1, 0, 32'h0, 0, "clr");
        op_const(0, 32'h20, 32'h0, 0, 32'h0, 0, "status_cleared");
        op_const(0, 32'h08, 32'h0, 0, 32'h0000_0006, 0, "bank_after_clr");

        // Count saturation
        for (int n = 0; n < 300; n++) begin
            rand_sdata();
            pulse();
        end
        op_const(0, 32'h20, 32'h0, 0, 32'h0000_FF03, 0, "status_saturated");

        // Random traffic against the model
        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                rand_sdata();
                pulse();
            end else begin
                off = $urandom_range(0, 11) * 4;
                if ($urandom_range(0, 7) == 0) off = off + $urandom_range(1, 3);
                a    = ($urandom() & 32'hFFFF_FFC0) | 32'(off);
                wr   = ($urandom_range(0, 2) == 0);
                snap = ($urandom_range(0, 4) == 0);
                if (snap) rand_sdata();
                op_model(wr, a, $urandom(), snap, $sformatf("rnd%0d", n));
            end
        end

        // Reset during the ACK of a CTRL write; snapshot during reset ignored
        rand_sdata();
        pulse();
        psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b1; paddr_i = 32'h24; pwdata_i = 32'h1;
        @(posedge clk_i); #1;
        penable_i = 1'b1;
        @(posedge clk_i); #1;
        check("rst_in_ack_pready", 32'(pready_o), 32'h1);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        check("rst_abort_pready", 32'(pready_o), 32'h0);
        check("rst_abort_pslverr", 32'(pslverr_o), 32'h0);
        check("rst_abort_prdata", prdata_o, 32'h0);
        psel_i = 1'b0; penable_i = 1'b0;
        snap_valid_i = 1'b1;
        @(posedge clk_i); #1;
        snap_valid_i = 1'b0;
        rst_i = 1'b0;
        m_reset();
        op_const(0, 32'h20, 32'h0, 0, 32'h0, 0, "status_after_rst");
        op_const(0, 32'h00, 32'h0, 0, 32'h0, 0, "runtime_after_rst");
        op_const(0, 32'h04, 32'h0, 0, 32'h0, 0, "shadow_after_rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/perf_snapshot_apb.md
PERF_SNAPSHOT_APB -- requirements
Module: perf_snapshot_apb

Interface
REQ-001 Parameter: AddrWidth, default 32, APB address width.
REQ-002 Parameter: CntWidth, default 64, snapshot counter width (fixed at 64; other values unsupported).
REQ-003 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_i  in  1  reset, synchronous and active-high.
REQ-005 snap_valid_i  in  1  one-cycle pulse; capture the four snapshot inputs this cycle.
REQ-006 snap_runtime_i  in  64  vector runtime cycle count.
REQ-007 snap_dcache_i / snap_icache_i / snap_sbfull_i  in  64 each  D$ stall, I$ stall and scoreboard-full counts.
REQ-008 psel_i, penable_i, pwrite_i  in  1 each  APB control.
REQ-009 paddr_i  in  AddrWidth  APB address; only bits [5:0] are decoded.
REQ-010 pwdata_i  in  32  APB write data.
REQ-011 prdata_o  out  32  read data; pready_o  out  1  transfer done; pslverr_o  out  1  error response.

Function
REQ-012 The register map SHALL be: 0x00/0x04 RUNTIME lo/hi, 0x08/0x0C DCACHE lo/hi, 0x10/0x14 ICACHE lo/hi, 0x18/0x1C SBFULL lo/hi, 0x20 STATUS (RO), 0x24 CTRL (WO).
REQ-013 STATUS SHALL be: bit0 valid, bit1 overrun (sticky), bits[15:8] snapshot count (saturates at 255), all other bits 0.
REQ-014 On snap_valid_i, the block SHALL load all four 64-bit banks in the same cycle, set valid, and increment the count; the new values are visible to APB reads from the next cycle.
REQ-015 If snap_valid_i arrives while valid is already 1, overrun SHALL be set and the banks SHALL still be overwritten.
REQ-016 An APB write to CTRL with pwdata_i[0]=1 SHALL clear valid, overrun and count; the banks SHALL be left unchanged.
REQ-017 If a CTRL clear and snap_valid_i land in the same cycle, the result SHALL be valid=1, overrun=0, count=1.
REQ-018 APB FSM states SHALL be IDLE and ACK.
REQ-019 IDLE -> ACK when psel_i & penable_i; ACK -> IDLE unconditionally.
REQ-020 pready_o SHALL be registered and equal to 1 only in ACK, giving exactly one wait state per transfer.
REQ-021 All read data, pslverr_o and write side effects SHALL be produced in the ACK cycle.
REQ-022 Reading a LO register SHALL return the bank's low word and latch the bank's high word into a single 32-bit shadow register.
REQ-023 Reading any HI register SHALL return the shadow, giving coherent 64-bit reads across a snapshot update.
REQ-024 pslverr_o=1 with prdata_o=0 SHALL be returned for: paddr_i[1:0]!=0; offset >0x24; a write to 0x00-0x20; a read of 0x24.
REQ-025 An erroring access SHALL have no side effect; in particular, the shadow SHALL not be updated.
REQ-026 Outside ACK, prdata_o SHALL be 0 and pslverr_o SHALL be 0.

Reset
REQ-027 While rst_i=1 at a clock edge, the FSM SHALL return to IDLE and all of the following SHALL be 0: banks, shadow, valid, overrun, count, pready_o, prdata_o, pslverr_o.
REQ-028 Reset asserted during ACK SHALL abort the transfer with no write side effect.
REQ-029 snap_valid_i SHALL be ignored in any cycle where rst_i=1.

Structure
REQ-030 Register offsets, STATUS bit positions and the FSM state enum SHALL live in a shared package, perf_snapshot_pkg.
REQ-031 One sub-module SHALL be used: perf_snapshot_bank, one 64-bit capture register instantiated four times.
REQ-032 The APB decode and FSM SHALL be in the top module.

Verification
REQ-033 Snapshot pulse with runtime=0x0000_0001_0000_00FF, then read 0x00 and 0x04 -> 0x0000_00FF, then 0x0000_0001; STATUS=0x0000_0101.
REQ-034 Read 0x08 (dcache=0xAAAA_0000_0000_0005); second snapshot with dcache=0xBBBB_0000_0000_0006; read 0x0C -> 0xAAAA_0000 (shadow); STATUS overrun=1, count=2.
REQ-035 Write CTRL=1 in the same ACK cycle as snap_valid_i -> STATUS=0x0000_0101.
REQ-036 Write 0x00, read 0x24, access 0x02, access 0x28 -> each has pready_o=1 one cycle after penable, pslverr_o=1, prdata_o=0, registers unchanged.
REQ-037 Send 300 snapshot pulses -> count reads 255, overrun=1.
REQ-038 Assert rst_i during ACK of a CTRL write -> pready_o=0 next cycle, STATUS=0.
